// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   OWNER_R0/R1 : requester identifiers used for owner/last_owner
//   cnt_width() : width of the optional ACCESS timeout counter (clamped 8..32)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic OWNER_R0 = 1'b0;
  localparam logic OWNER_R1 = 1'b1;

  // Bits needed to count up to n, clamped to 8..32.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker.
//   req_i[1:0]      : request per requester (bit index = requester id)
//   last_owner_i    : id of the most recently granted requester
//   grant_valid_c_o : at least one request present (combinational)
//   grant_id_c_o    : chosen requester id (combinational)
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       grant_valid_c_o,
  output logic       grant_id_c_o
);

  // On a tie the requester that did not go last wins.
  always_comb begin
    grant_valid_c_o = |req_i;
    grant_id_c_o    = OWNER_R0;
    if (req_i == 2'b11) begin
      grant_id_c_o = ~last_owner_i;
    end else if (req_i[1]) begin
      grant_id_c_o = OWNER_R1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-style memory port between requesters R0 and R1.
// Round-robin grant, one access in flight, IDLE -> ACCESS -> RESP per access.
// Ports:
//   HCLK, HRESETn                  clock, async active-low reset
//   Rx_MEN/MADDR/MDIN/MWE (in)     requester x access request, held until Rx_MDONE
//   Rx_MDONE/MERROR/MDOUT (out)    requester x completion pulse, error, last read data
//   MEN/MADDR/MDIN/MWE (out)       registered memory command of the current owner
//   MDONE/MERROR/MDOUT (in)        memory completion, error, read data
//   BUSY (out)                     high in ARB_ACCESS or ARB_RESP
// Build option: define MEM_ARB_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// cycles in ARB_ACCESS with an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      R0_MEN,
  input  logic [ADDR_WIDTH-1:0]     R0_MADDR,
  input  logic [DATA_WIDTH-1:0]     R0_MDIN,
  input  logic [DATA_WIDTH/8-1:0]   R0_MWE,
  output logic                      R0_MDONE,
  output logic                      R0_MERROR,
  output logic [DATA_WIDTH-1:0]     R0_MDOUT,
  input  logic                      R1_MEN,
  input  logic [ADDR_WIDTH-1:0]     R1_MADDR,
  input  logic [DATA_WIDTH-1:0]     R1_MDIN,
  input  logic [DATA_WIDTH/8-1:0]   R1_MWE,
  output logic                      R1_MDONE,
  output logic                      R1_MERROR,
  output logic [DATA_WIDTH-1:0]     R1_MDOUT,
  output logic                      MEN,
  output logic [ADDR_WIDTH-1:0]     MADDR,
  output logic [DATA_WIDTH-1:0]     MDIN,
  output logic [DATA_WIDTH/8-1:0]   MWE,
  input  logic                      MDONE,
  input  logic                      MERROR,
  input  logic [DATA_WIDTH-1:0]     MDOUT,
  output logic                      BUSY
);

  localparam int unsigned WE_W = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic                  men_q, men_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdin_q, mdin_d;
  logic [WE_W-1:0]       mwe_q, mwe_d;
  logic                  busy_q, busy_d;
  logic                  r0_mdone_q, r0_mdone_d, r1_mdone_q, r1_mdone_d;
  logic                  r0_merror_q, r0_merror_d, r1_merror_q, r1_merror_d;
  logic [DATA_WIDTH-1:0] r0_mdout_q, r0_mdout_d, r1_mdout_q, r1_mdout_d;

  logic                  grant_valid_c;
  logic                  grant_id_c;
  logic                  timeout_c;

  // Round-robin choice between the two requesters.
  mem_arb_rr2 u_rr2 (
    .req_i           ({R1_MEN, R0_MEN}),
    .last_owner_i    (last_owner_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_id_c_o    (grant_id_c)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on entry to ARB_ACCESS and counts the cycles spent there.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_ACCESS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the edge that ends the TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_c = (state_q == ARB_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_c      = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    men_d        = men_q;
    maddr_d      = maddr_q;
    mdin_d       = mdin_q;
    mwe_d        = mwe_q;
    busy_d       = busy_q;
    r0_mdone_d   = 1'b0;
    r1_mdone_d   = 1'b0;
    r0_merror_d  = 1'b0;
    r1_merror_d  = 1'b0;
    r0_mdout_d   = r0_mdout_q;
    r1_mdout_d   = r1_mdout_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid_c) begin
          owner_d      = grant_id_c;
          last_owner_d = grant_id_c;
          men_d        = 1'b1;
          busy_d       = 1'b1;
          maddr_d      = (grant_id_c == OWNER_R1) ? R1_MADDR : R0_MADDR;
          mdin_d       = (grant_id_c == OWNER_R1) ? R1_MDIN  : R0_MDIN;
          mwe_d        = (grant_id_c == OWNER_R1) ? R1_MWE   : R0_MWE;
          state_d      = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        if (MDONE) begin
          men_d   = 1'b0;
          state_d = ARB_RESP;
          if (owner_q == OWNER_R1) begin
            r1_mdone_d  = 1'b1;
            r1_merror_d = MERROR;
            if (mwe_q == '0) r1_mdout_d = MDOUT;
          end else begin
            r0_mdone_d  = 1'b1;
            r0_merror_d = MERROR;
            if (mwe_q == '0) r0_mdout_d = MDOUT;
          end
        end else if (timeout_c) begin
          // Abort: error response, read data left untouched.
          men_d   = 1'b0;
          state_d = ARB_RESP;
          if (owner_q == OWNER_R1) begin
            r1_mdone_d  = 1'b1;
            r1_merror_d = 1'b1;
          end else begin
            r0_mdone_d  = 1'b1;
            r0_merror_d = 1'b1;
          end
        end
      end

      ARB_RESP: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end

      default: begin
        men_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_R0;
      last_owner_q <= OWNER_R1;
      men_q        <= 1'b0;
      maddr_q      <= '0;
      mdin_q       <= '0;
      mwe_q        <= '0;
      busy_q       <= 1'b0;
      r0_mdone_q   <= 1'b0;
      r1_mdone_q   <= 1'b0;
      r0_merror_q  <= 1'b0;
      r1_merror_q  <= 1'b0;
      r0_mdout_q   <= '0;
      r1_mdout_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      men_q        <= men_d;
      maddr_q      <= maddr_d;
      mdin_q       <= mdin_d;
      mwe_q        <= mwe_d;
      busy_q       <= busy_d;
      r0_mdone_q   <= r0_mdone_d;
      r1_mdone_q   <= r1_mdone_d;
      r0_merror_q  <= r0_merror_d;
      r1_merror_q  <= r1_merror_d;
      r0_mdout_q   <= r0_mdout_d;
      r1_mdout_q   <= r1_mdout_d;
    end
  end

  assign MEN       = men_q;
  assign MADDR     = maddr_q;
  assign MDIN      = mdin_q;
  assign MWE       = mwe_q;
  assign BUSY      = busy_q;
  assign R0_MDONE  = r0_mdone_q;
  assign R0_MERROR = r0_merror_q;
  assign R0_MDOUT  = r0_mdout_q;
  assign R1_MDONE  = r1_mdone_q;
  assign R1_MERROR = r1_merror_q;
  assign R1_MDOUT  = r1_mdout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (32-bit data/address, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic        R0_MEN, R1_MEN;
  logic [31:0] R0_MADDR, R1_MADDR, R0_MDIN, R1_MDIN;
  logic [3:0]  R0_MWE, R1_MWE;
  logic        R0_MDONE, R1_MDONE, R0_MERROR, R1_MERROR;
  logic [31:0] R0_MDOUT, R1_MDOUT;
  logic        MEN;
  logic [31:0] MADDR, MDIN;
  logic [3:0]  MWE;
  logic        MDONE, MERROR;
  logic [31:0] MDOUT;
  logic        BUSY;

  int nvec = 0;
  int nerr = 0;

  mem_port_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .R0_MEN    (R0_MEN),
    .R0_MADDR  (R0_MADDR),
    .R0_MDIN   (R0_MDIN),
    .R0_MWE    (R0_MWE),
    .R0_MDONE  (R0_MDONE),
    .R0_MERROR (R0_MERROR),
    .R0_MDOUT  (R0_MDOUT),
    .R1_MEN    (R1_MEN),
    .R1_MADDR  (R1_MADDR),
    .R1_MDIN   (R1_MDIN),
    .R1_MWE    (R1_MWE),
    .R1_MDONE  (R1_MDONE),
    .R1_MERROR (R1_MERROR),
    .R1_MDOUT  (R1_MDOUT),
    .MEN       (MEN),
    .MADDR     (MADDR),
    .MDIN      (MDIN),
    .MWE       (MWE),
    .MDONE     (MDONE),
    .MERROR    (MERROR),
    .MDOUT     (MDOUT),
    .BUSY      (BUSY)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_inputs();
    R0_MEN = 0; R0_MADDR = '0; R0_MDIN = '0; R0_MWE = '0;
    R1_MEN = 0; R1_MADDR = '0; R1_MDIN = '0; R1_MWE = '0;
    MDONE = 0; MERROR = 0; MDOUT = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    HRESETn = 0;
    repeat (2) tick();
    @(negedge HCLK);
    HRESETn = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    HRESETn = 0;
    #13;
    nvec++; if ({MEN, BUSY, R0_MDONE, R1_MDONE, R0_MERROR, R1_MERROR} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctrl: got %b want 000000", {MEN, BUSY, R0_MDONE, R1_MDONE, R0_MERROR, R1_MERROR}); end
    nvec++; if ({MADDR, MDIN, MWE, R0_MDOUT, R1_MDOUT} !== '0) begin
      nerr++; $display("FAIL reset_data: MADDR=%h MDIN=%h MWE=%h R0_MDOUT=%h R1_MDOUT=%h want 0", MADDR, MDIN, MWE, R0_MDOUT, R1_MDOUT); end
    @(negedge HCLK);
    HRESETn = 1;
    repeat (2) tick();
    nvec++; if ({MEN, BUSY} !== 2'b00) begin
      nerr++; $display("FAIL idle_after_reset: MEN/BUSY=%b want 00", {MEN, BUSY}); end
  endtask

  task automatic test_r0_read();
    R0_MADDR = 32'h2000_0010; R0_MWE = 4'h0; R0_MEN = 1;
    MDONE = 1; MDOUT = 32'hDEAD_BEEF;
    tick();
    nvec++; if ({MEN, BUSY, R0_MDONE} !== 3'b110) begin
      nerr++; $display("FAIL r0_grant: MEN/BUSY/R0_MDONE=%b want 110", {MEN, BUSY, R0_MDONE}); end
    nvec++; if (MADDR !== 32'h2000_0010) begin
      nerr++; $display("FAIL r0_maddr: got %h want 20000010", MADDR); end
    tick();
    nvec++; if ({MEN, R0_MDONE, R0_MERROR, R1_MDONE} !== 4'b0100) begin
      nerr++; $display("FAIL r0_done: MEN/R0_MDONE/R0_MERROR/R1_MDONE=%b want 0100", {MEN, R0_MDONE, R0_MERROR, R1_MDONE}); end
    nvec++; if (R0_MDOUT !== 32'hDEAD_BEEF) begin
      nerr++; $display("FAIL r0_mdout: got %h want deadbeef", R0_MDOUT); end
    R0_MEN = 0;
    tick();
    nvec++; if ({R0_MDONE, BUSY} !== 2'b00) begin
      nerr++; $display("FAIL r0_resp_end: R0_MDONE/BUSY=%b want 00", {R0_MDONE, BUSY}); end
    nvec++; if (R0_MDOUT !== 32'hDEAD_BEEF) begin
      nerr++; $display("FAIL r0_mdout_hold: got %h want deadbeef", R0_MDOUT); end
    MDONE = 0;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    int n = 0;
    int r0_done = 0;
    int r1_done = 0;
    apply_reset();
    R0_MADDR = 32'h1000_0000; R0_MWE = 4'h0; R0_MDIN = '0;
    R1_MADDR = 32'h1000_0100; R1_MWE = 4'hF; R1_MDIN = 32'h1234_5678;
    MDONE = 1; MDOUT = 32'hCAFE_0001;
    R0_MEN = 1; R1_MEN = 1;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (R0_MDONE) r0_done++;
      if (R1_MDONE) r1_done++;
      nvec++; if ((R0_MDONE & R1_MDONE) !== 1'b0) begin
        nerr++; $display("FAIL rr_both_done: cycle %0d both MDONE high", c); end
      if (MEN === 1'b1 && n < 4) begin
        exp_addr = (n % 2 == 0) ? 32'h1000_0000 : 32'h1000_0100;
        nvec++; if (MADDR !== exp_addr) begin
          nerr++; $display("FAIL rr_order: grant %0d MADDR=%h want %h", n, MADDR, exp_addr); end
        if (n % 2 == 1) begin
          nvec++; if ({MWE, MDIN} !== {4'hF, 32'h1234_5678}) begin
            nerr++; $display("FAIL rr_write_cmd: MWE=%h MDIN=%h want f 12345678", MWE, MDIN); end
        end
        n++;
      end
    end
    R0_MEN = 0; R1_MEN = 0;
    repeat (4) tick();
    nvec++; if (n !== 4) begin
      nerr++; $display("FAIL rr_grants: got %0d grants want 4", n); end
    nvec++; if ({r0_done, r1_done} !== {32'd2, 32'd2}) begin
      nerr++; $display("FAIL rr_done_count: r0=%0d r1=%0d want 2 2", r0_done, r1_done); end
    nvec++; if (R1_MDOUT !== 32'h0) begin
      nerr++; $display("FAIL rr_r1_mdout: got %h want 00000000", R1_MDOUT); end
    nvec++; if (R0_MDOUT !== 32'hCAFE_0001) begin
      nerr++; $display("FAIL rr_r0_mdout: got %h want cafe0001", R0_MDOUT); end
    MDONE = 0;
  endtask

  task automatic test_delayed_error();
    apply_reset();
    R0_MADDR = 32'h3000_0040; R0_MWE = 4'h0; R0_MEN = 1;
    R1_MADDR = 32'h3000_0080; R1_MWE = 4'h0; R1_MEN = 1;
    MDONE = 0; MERROR = 0; MDOUT = 32'h0BAD_0BAD;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++; if ({MEN, R0_MDONE, R1_MDONE} !== 3'b100) begin
        nerr++; $display("FAIL dly_access: cycle %0d MEN/R0_MDONE/R1_MDONE=%b want 100", i, {MEN, R0_MDONE, R1_MDONE}); end
      nvec++; if (MADDR !== 32'h3000_0040) begin
        nerr++; $display("FAIL dly_maddr: cycle %0d got %h want 30000040", i, MADDR); end
      if (i == 5) begin MDONE = 1; MERROR = 1; end
    end
    tick();
    nvec++; if ({MEN, R0_MDONE, R0_MERROR, R1_MDONE, R1_MERROR} !== 5'b01100) begin
      nerr++; $display("FAIL dly_done: MEN/R0_MDONE/R0_MERROR/R1_MDONE/R1_MERROR=%b want 01100", {MEN, R0_MDONE, R0_MERROR, R1_MDONE, R1_MERROR}); end
    nvec++; if (R0_MDOUT !== 32'h0BAD_0BAD) begin
      nerr++; $display("FAIL dly_mdout: got %h want 0bad0bad", R0_MDOUT); end
    R0_MEN = 0; MERROR = 0;
    tick();
    nvec++; if ({R0_MDONE, R0_MERROR} !== 2'b00) begin
      nerr++; $display("FAIL dly_pulse_len: R0_MDONE/R0_MERROR=%b want 00", {R0_MDONE, R0_MERROR}); end
    tick();
    nvec++; if ({MEN, MADDR} !== {1'b1, 32'h3000_0080}) begin
      nerr++; $display("FAIL dly_r1_next: MEN=%b MADDR=%h want 1 30000080", MEN, MADDR); end
    R1_MEN = 0;
    repeat (3) tick();
    MDONE = 0;
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    R0_MADDR = 32'h4000_0000; R0_MWE = 4'h0; R0_MEN = 1;
    MDONE = 0;
    tick();
    nvec++; if (MEN !== 1'b1) begin
      nerr++; $display("FAIL rstmid_access: MEN=%b want 1", MEN); end
    #2 HRESETn = 0;
    #1;
    nvec++; if ({MEN, BUSY, R0_MDONE, R1_MDONE} !== 4'b0000) begin
      nerr++; $display("FAIL rstmid_async: MEN/BUSY/R0_MDONE/R1_MDONE=%b want 0000", {MEN, BUSY, R0_MDONE, R1_MDONE}); end
    R1_MADDR = 32'h4000_0100; R1_MWE = 4'h0; R1_MEN = 1;
    MDONE = 1;
    @(negedge HCLK);
    HRESETn = 1;
    tick();
    nvec++; if ({MEN, MADDR} !== {1'b1, 32'h4000_0000}) begin
      nerr++; $display("FAIL rstmid_r0_first: MEN=%b MADDR=%h want 1 40000000", MEN, MADDR); end
    tick();
    nvec++; if ({R0_MDONE, R1_MDONE} !== 2'b10) begin
      nerr++; $display("FAIL rstmid_done: R0_MDONE/R1_MDONE=%b want 10", {R0_MDONE, R1_MDONE}); end
    R0_MEN = 0; R1_MEN = 0;
    repeat (4) tick();
    MDONE = 0;
  endtask

  task automatic test_idle_mdone();
    apply_reset();
    MDONE = 1; MERROR = 1; MDOUT = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if ({MEN, BUSY, R0_MDONE, R1_MDONE, R0_MERROR, R1_MERROR} !== 6'b0) begin
        nerr++; $display("FAIL idle_mdone: cycle %0d outputs=%b want 000000", i, {MEN, BUSY, R0_MDONE, R1_MDONE, R0_MERROR, R1_MERROR}); end
    end
    nvec++; if ({R0_MDOUT, R1_MDOUT} !== 64'h0) begin
      nerr++; $display("FAIL idle_mdout: R0=%h R1=%h want 0 0", R0_MDOUT, R1_MDOUT); end
    MDONE = 0; MERROR = 0;
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    R1_MADDR = 32'h5000_0000; R1_MWE = 4'h0; R1_MEN = 1;
    MDONE = 0; MDOUT = 32'h1111_1111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      nvec++; if ({MEN, R1_MDONE} !== 2'b10) begin
        nerr++; $display("FAIL to_access: cycle %0d MEN/R1_MDONE=%b want 10", i, {MEN, R1_MDONE}); end
    end
    tick();
    nvec++; if ({MEN, R1_MDONE, R1_MERROR, R0_MDONE} !== 4'b0110) begin
      nerr++; $display("FAIL to_abort: MEN/R1_MDONE/R1_MERROR/R0_MDONE=%b want 0110", {MEN, R1_MDONE, R1_MERROR, R0_MDONE}); end
    nvec++; if (R1_MDOUT !== 32'h0) begin
      nerr++; $display("FAIL to_mdout: got %h want 00000000", R1_MDOUT); end
    R1_MEN = 0; MDONE = 1;
    tick();
    nvec++; if ({R1_MDONE, BUSY} !== 2'b00) begin
      nerr++; $display("FAIL to_late1: R1_MDONE/BUSY=%b want 00", {R1_MDONE, BUSY}); end
    tick();
    nvec++; if ({R1_MDONE, R1_MDOUT} !== {1'b0, 32'h0}) begin
      nerr++; $display("FAIL to_late2: R1_MDONE=%b R1_MDOUT=%h want 0 0", R1_MDONE, R1_MDOUT); end
    MDONE = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_r0_read();
    test_round_robin();
    test_delayed_error();
    test_reset_mid_access();
    test_idle_mdone();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
